// File: rtl/color_pkg.sv
// color_pkg: shared color/filter/scale encodings and the emulated sensor's base half-period table
package color_pkg;
  localparam logic [2:0] COLOR_NONE = 3'd0;
  localparam logic [2:0] RED        = 3'd1;
  localparam logic [2:0] GREEN      = 3'd2;
  localparam logic [2:0] BLUE       = 3'd3;
  localparam logic [2:0] YELLOW     = 3'd4;
  localparam logic [2:0] CYAN       = 3'd5;
  localparam logic [2:0] MAGENTA    = 3'd6;
  localparam logic [2:0] WHITE      = 3'd7;
  localparam logic [1:0] FILTER_RED   = 2'b00;
  localparam logic [1:0] FILTER_BLUE  = 2'b01;
  localparam logic [1:0] FILTER_CLEAR = 2'b10;
  localparam logic [1:0] FILTER_GREEN = 2'b11;
  localparam logic [1:0] SCALE_OFF = 2'b00;
  localparam logic [1:0] SCALE_2   = 2'b01;
  localparam logic [1:0] SCALE_20  = 2'b10;
  localparam logic [1:0] SCALE_100 = 2'b11;
  localparam logic [5:0] MUL_2   = 6'd50;
  localparam logic [5:0] MUL_20  = 6'd5;
  localparam logic [5:0] MUL_100 = 6'd1;
  // rows: color code, columns: filter code (red, blue, clear, green)
  localparam logic [15:0] BASE_HALF [8][4] = '{
    '{16'd0,   16'd0,   16'd0,   16'd0},
    '{16'd100, 16'd20,  16'd120, 16'd25},
    '{16'd20,  16'd30,  16'd130, 16'd90},
    '{16'd15,  16'd80,  16'd110, 16'd30},
    '{16'd90,  16'd15,  16'd160, 16'd85},
    '{16'd20,  16'd70,  16'd150, 16'd75},
    '{16'd85,  16'd75,  16'd155, 16'd20},
    '{16'd95,  16'd90,  16'd180, 16'd92}
  };
  typedef enum logic [1:0] {ST_OFF, ST_SETTLE, ST_RUN} state_t;
  function automatic logic [21:0] half_period_of(input logic [2:0] color, input logic [1:0] filter,
                                                 input logic [1:0] scale);
    logic [15:0] base;
    logic [5:0] mul;
    base = BASE_HALF[color][filter] == 16'd0 ? 16'd1 : BASE_HALF[color][filter];
    mul = scale == SCALE_2 ? MUL_2 : scale == SCALE_20 ? MUL_20 : MUL_100;
    return {6'd0, base} * {16'd0, mul};
  endfunction
endpackage

// File: rtl/period_gen.sv
// period_gen: reloadable half-period counter driving the square-wave toggle flop
module period_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        enable,
  input  logic [21:0] half_period,
  output logic        out
);
  logic [21:0] cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (load) begin
      cnt <= half_period;
      out <= 1'b1;
    end else if (!enable) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (cnt <= 22'd1) begin
      cnt <= half_period;
      out <= ~out;
    end else begin
      cnt <= cnt - 22'd1;
    end
  end
endmodule

// File: rtl/tcs3200_emulator.sv
// tcs3200_emulator: TCS3200 color sensor model with OFF/SETTLE/RUN control and a color handshake
module tcs3200_emulator
  import color_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] s2_s3,
  input  logic [1:0] s0_s1,
  input  logic [2:0] color_in,
  input  logic       color_valid,
  output logic       color_ready,
  output logic       sensor_out,
  output logic       settling,
  output logic [2:0] cur_color
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  if (SETTLE_CYCLES < 1 || CLK_HZ < 1) begin : g_bad_param
    $error("tcs3200_emulator: SETTLE_CYCLES and CLK_HZ must be positive");
  end
  state_t state, next_state;
  logic [1:0] s2_s3_q, s2_s3_p, s0_s1_q, s0_s1_p;
  logic [SW-1:0] settle_cnt;
  logic xfer, trig, restart;
  logic [21:0] half_period;
  always_comb begin
    xfer = color_valid && color_ready;
    trig = (s2_s3_q != s2_s3_p) || (s0_s1_q != s0_s1_p) || xfer;
    next_state = s0_s1_q == SCALE_OFF ? ST_OFF :
                 state == ST_OFF ? ST_SETTLE :
                 trig ? ST_SETTLE :
                 (state == ST_SETTLE && settle_cnt == '0) ? ST_RUN : state;
    restart = next_state == ST_SETTLE && (state != ST_SETTLE || trig);
    half_period = half_period_of(cur_color, s2_s3_q, s0_s1_q);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_OFF;
      s2_s3_q     <= '0;
      s2_s3_p     <= '0;
      s0_s1_q     <= '0;
      s0_s1_p     <= '0;
      settle_cnt  <= '0;
      settling    <= 1'b0;
      color_ready <= 1'b0;
      cur_color   <= COLOR_NONE;
    end else begin
      s2_s3_q     <= s2_s3;
      s2_s3_p     <= s2_s3_q;
      s0_s1_q     <= s0_s1;
      s0_s1_p     <= s0_s1_q;
      state       <= next_state;
      settling    <= next_state == ST_SETTLE;
      color_ready <= next_state != ST_SETTLE;
      settle_cnt  <= next_state != ST_SETTLE ? '0 : restart ? SETTLE_LOAD : settle_cnt - SW'(1);
      if (xfer) cur_color <= color_in;
    end
  end
  // half_period is sampled only at RUN entry and on each reload inside period_gen
  period_gen u_period_gen (
    .clk         (clk),
    .rst         (rst),
    .load        (state == ST_SETTLE && next_state == ST_RUN),
    .enable      (next_state == ST_RUN),
    .half_period (half_period),
    .out         (sensor_out)
  );
endmodule

// File: tb/tb_tcs3200_emulator.sv
// tb_tcs3200_emulator: directed and randomized checks of settle timing, periods and handshake
module tb_tcs3200_emulator;
  localparam int SETTLE = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] s2_s3 = 2'b00;
  logic [1:0] s0_s1 = 2'b11;
  logic [2:0] color_in = 3'd0;
  logic color_valid = 1'b0;
  logic color_ready, sensor_out, settling;
  logic [2:0] cur_color;
  int n_asserts = 0;
  int n_fails = 0;
  int base_tbl [8][4] = '{
    '{0, 0, 0, 0}, '{100, 20, 120, 25}, '{20, 30, 130, 90}, '{15, 80, 110, 30},
    '{90, 15, 160, 85}, '{20, 70, 150, 75}, '{85, 75, 155, 20}, '{95, 90, 180, 92}
  };

  tcs3200_emulator #(.CLK_HZ(50_000_000), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst), .s2_s3(s2_s3), .s0_s1(s0_s1), .color_in(color_in),
    .color_valid(color_valid), .color_ready(color_ready), .sensor_out(sensor_out),
    .settling(settling), .cur_color(cur_color)
  );

  always #5 clk = ~clk;

  function automatic int model_half(input int c, input int f, input logic [1:0] sc);
    int b;
    b = base_tbl[c][f] == 0 ? 1 : base_tbl[c][f];
    return b * (sc == 2'b01 ? 50 : sc == 2'b10 ? 5 : 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // waits for SETTLE, then checks its length and one full output period
  task automatic measure(input string tag, input int exp_lat, input int exp_half);
    int n;
    logic quiet;
    n = 0;
    while (settling !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check({tag, "_latency"}, n, exp_lat);
    n = 0;
    quiet = 1'b1;
    while (settling === 1'b1 && n < 100) begin
      if (sensor_out !== 1'b0 || color_ready !== 1'b0) quiet = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, "_settle_len"}, n, SETTLE);
    check({tag, "_settle_quiet"}, quiet, 1);
    check({tag, "_run_start"}, sensor_out, 1);
    n = 0;
    while (sensor_out === 1'b1 && n < exp_half + 20) begin @(negedge clk); n++; end
    check({tag, "_high"}, n, exp_half);
    n = 0;
    while (sensor_out === 1'b0 && settling === 1'b0 && n < exp_half + 20) begin @(negedge clk); n++; end
    check({tag, "_low"}, n, exp_half);
  endtask

  task automatic boot(input string tag);
    s0_s1 = 2'b11;
    s2_s3 = 2'b00;
    color_in = 3'd1;
    color_valid = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check({tag, "_ready_after_reset"}, color_ready, 1);
    check({tag, "_no_settle_yet"}, settling, 0);
    @(negedge clk);
    check({tag, "_red_loaded"}, cur_color, 1);
    check({tag, "_settle_begins"}, settling, 1);
    color_valid = 1'b0;
    measure(tag, 0, 100);
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_sensor"}, sensor_out, 0);
    check({tag, "_settling"}, settling, 0);
    check({tag, "_ready"}, color_ready, 0);
    check({tag, "_color"}, cur_color, 0);
  endtask

  initial begin
    int n;
    logic held;
    logic [1:0] sc;
    int f, c;
    #2 rst = 1'b0;
    #1 reset_outputs("reset");
    boot("red_boot");

    // slow down to 2 % scaling from RUN
    s0_s1 = 2'b01;
    measure("scale_2pct", 2, model_half(1, 0, 2'b01));

    // color offered during SETTLE must wait for RUN
    s0_s1 = 2'b11;
    @(negedge clk);
    @(negedge clk);
    check("hold_settle_seen", settling, 1);
    color_in = 3'd3;
    color_valid = 1'b1;
    n = 0;
    held = 1'b1;
    while (settling === 1'b1 && n < 100) begin
      if (color_ready !== 1'b0) held = 1'b0;
      @(negedge clk);
      n++;
    end
    check("hold_settle_len", n, SETTLE);
    check("hold_ready_low", held, 1);
    check("hold_run_ready", color_ready, 1);
    check("hold_color_kept", cur_color, 1);
    check("hold_run_high", sensor_out, 1);
    @(negedge clk);
    check("hold_blue_taken", cur_color, 3);
    check("hold_resettle", settling, 1);
    color_valid = 1'b0;
    measure("blue", 0, model_half(3, 0, 2'b11));

    // power-down from RUN
    s0_s1 = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("off_sensor", sensor_out, 0);
    check("off_settling", settling, 0);
    check("off_ready", color_ready, 1);
    repeat (5) @(negedge clk);
    check("off_hold", sensor_out, 0);
    s0_s1 = 2'b11;
    measure("off_resume", 2, model_half(3, 0, 2'b11));

    // filter change and transfer landing on the same cycle
    s2_s3 = 2'b11;
    @(negedge clk);
    color_in = 3'd4;
    color_valid = 1'b1;
    @(negedge clk);
    color_valid = 1'b0;
    check("combo_color", cur_color, 4);
    check("combo_settle", settling, 1);
    measure("combo", 0, model_half(4, 3, 2'b11));

    // zero table entry behaves as one
    s0_s1 = 2'b10;
    s2_s3 = 2'b10;
    @(negedge clk);
    color_in = 3'd0;
    color_valid = 1'b1;
    @(negedge clk);
    color_valid = 1'b0;
    check("none_color", cur_color, 0);
    measure("none", 0, model_half(0, 2, 2'b10));

    for (int i = 0; i < 8; i++) begin
      sc = $urandom_range(0, 1) ? 2'b11 : 2'b10;
      f = $urandom_range(0, 3);
      c = $urandom_range(0, 7);
      s0_s1 = sc;
      s2_s3 = 2'(f);
      @(negedge clk);
      color_in = 3'(c);
      color_valid = 1'b1;
      @(negedge clk);
      color_valid = 1'b0;
      check($sformatf("rand%0d_color", i), cur_color, c);
      check($sformatf("rand%0d_settle", i), settling, 1);
      measure($sformatf("rand%0d", i), 0, model_half(c, f, sc));
    end

    // asynchronous reset in the middle of a high phase
    check("pre_reset_high", sensor_out, 1);
    #2 rst = 1'b0;
    #1 reset_outputs("async_reset");
    boot("reboot");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule

// File: doc/tcs3200_emulator.md
TCS3200_EMULATOR -- requirements
Module: tcs3200_emulator

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: system clock frequency in Hz, for documentation and bench timing only.
REQ-002 Parameter SETTLE_CYCLES, default 1000: filter/scale settling time in clk cycles; minimum value 1.
REQ-003 Port clk  input  1: the single system clock; all logic is on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous assert, active-low.
REQ-005 Port s2_s3  input  2: filter select. 00 = red, 01 = blue, 10 = clear, 11 = green.
REQ-006 Port s0_s1  input  2: output scaling. 00 = power-down, 01 = 2 %, 10 = 20 %, 11 = 100 %.
REQ-007 Port color_in  input  3: color code to emulate, using the shared color encoding.
REQ-008 Port color_valid  input  1: color_in is valid this cycle.
REQ-009 Port color_ready  output  1: the emulator accepts color_in this cycle.
REQ-010 Port sensor_out  output  1: emulated TCS3200 square-wave output.
REQ-011 Port settling  output  1: high while in state SETTLE.
REQ-012 Port cur_color  output  3: the color code currently being emulated.

Function
REQ-013 A color transfer occurs on any cycle where color_valid and color_ready are both high; cur_color updates on the next edge.
REQ-014 color_ready shall be high in states OFF and RUN and low in SETTLE; color_valid held high during SETTLE waits without loss.
REQ-015 s2_s3 and s0_s1 shall each be registered once, giving 1 cycle of latency; change detection compares the registered value with its previous value.
REQ-016 The state machine has three states: OFF, SETTLE and RUN.
REQ-017 Any state goes to OFF when the registered s0_s1 equals 00; in OFF, sensor_out is 0 and the counter is cleared.
REQ-018 OFF goes to SETTLE when the registered s0_s1 is not 00.
REQ-019 RUN goes to SETTLE on a registered s2_s3 change, a registered s0_s1 change to a non-zero value, or a color transfer.
REQ-020 A trigger from REQ-019 arriving while in SETTLE restarts the settle count.
REQ-021 In SETTLE, sensor_out is held 0 for exactly SETTLE_CYCLES cycles, then the state goes to RUN.
REQ-022 On entry to RUN, sensor_out goes to 1 and the half-period counter loads half_period.
REQ-023 In RUN, sensor_out toggles each time the counter expires; the counter then reloads half_period.
REQ-024 half_period = BASE_HALF[cur_color][filter] x SCALE[s0_s1], where SCALE is 1 for 11, 5 for 10 and 50 for 01.
REQ-025 BASE_HALF entries are 16 bits; the product is 22 bits unsigned with no truncation.
REQ-026 A BASE_HALF entry of 0 is treated as 1.
REQ-027 half_period is latched on RUN entry and on each reload, so period changes take effect only through SETTLE.
REQ-028 If a color transfer and a filter change occur in the same cycle, a single SETTLE is entered and both take effect.

Reset
REQ-029 While rst is low: state = OFF, sensor_out = 0, settling = 0, color_ready = 0, cur_color = COLOR_NONE (000), counters = 0, input registers = 0.
REQ-030 After rst deasserts, color_ready = 1 from the first clock edge, and the FSM follows REQ-017/018 from the registered inputs.
REQ-031 Reset asserted mid-period or mid-SETTLE forces the outputs of REQ-029 immediately, without waiting for a clock edge.

Structure
REQ-032 Package color_pkg holds the color code constants (COLOR_NONE, RED, GREEN, BLUE, YELLOW, CYAN, MAGENTA, WHITE = 000..111), the filter code constants, the SCALE constants and the BASE_HALF table.
REQ-033 The color receiver and the identifier import the same package, so the emulator and the identifier agree on encodings.
REQ-034 One sub-module, period_gen, holds the 22-bit reloadable half-period counter and toggle flop, with inputs load, half_period and enable.
REQ-035 The FSM and the handshake logic stay in tcs3200_emulator.

Verification
REQ-036 Reset with s0_s1 = 11, s2_s3 = 00, color RED (BASE_HALF = 100), SETTLE_CYCLES = 10 -> sensor_out low for 10 cycles, then a 200-cycle period square wave.
REQ-037 Switch s0_s1 from 11 to 01 in RUN -> 1 cycle register latency, SETTLE of 10 cycles, then the period is 200 x 50 = 10000 cycles.
REQ-038 color_valid held high with color_in = BLUE during SETTLE -> color_ready low until RUN; transfer on the first RUN cycle; cur_color = 011; new SETTLE.
REQ-039 s0_s1 = 00 while in RUN -> next cycle after registration: sensor_out = 0, state OFF, color_ready = 1.
REQ-040 Same-cycle s2_s3 change and color transfer -> exactly one SETTLE of 10 cycles; the new period matches the new color and filter.
REQ-041 rst pulsed low mid-period -> sensor_out = 0 and cur_color = 000 asynchronously; the sequence of REQ-036 restarts after release.
